dot_matrix_scanner: RTL and testbench
=====================================

# dot_matrix_scanner

Parametrised row-scanning driver for multiplexed LED dot-matrix panels, replacing the fixed 8x8 keypad-to-matrix driver. It accepts a full frame bitmap over a valid/ready handshake into a shadow buffer and swaps it into the active buffer only at frame boundaries, so frames never tear. Rows are scanned with a programmable dwell, an inter-row blanking cycle and PWM brightness. It sits between the keypad/frame-generation logic and the panel pins.

## Interface
- ROWS, 8, panel rows; ≥2, even.
- COLS, 8, panel columns; ≥2, even.
- DWELL, 16, clock cycles per row; ≥4.
- PWM_BITS, 3, brightness resolution.
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low.
- frame_data  input  ROWS*COLS  bitmap; row r occupies bits [ROWS*COLS-1-r*COLS -: COLS], MSB = leftmost column.
- frame_valid  input  1  frame_data valid.
- frame_ready  output  1  shadow buffer free.
- brightness  input  PWM_BITS  0 = dimmest nonzero duty, all-ones = full on.
- scale  input  1  2x2 pixel replication (only with DOT_SCALE_EN).
- dot_row  output  ROWS  one-hot active-low row select.
- dot_col  output  COLS  active-high column drive.
- frame_sync  output  1  one-cycle pulse when the active buffer is swapped.

## Operation
- Counters: dwell_cnt 0..DWELL-1, row_idx 0..ROWS-1. dwell_cnt wraps at DWELL-1 and row_idx advances then; row_idx wraps ROWS-1 -> 0.
- Handshake: a transfer occurs when frame_valid && frame_ready. frame_data is captured into the shadow buffer, the pending flag is set and frame_ready drops the next cycle.
- Swap: on the cycle with row_idx==ROWS-1, dwell_cnt==DWELL-1 and pending set:
  - active <= shadow; pending clears; frame_ready rises the next cycle.
  - frame_sync pulses on the following cycle, coincident with row 0 output.
  - Without a pending frame, the active buffer is kept and frame_sync stays 0.
- Row output: dot_row = ~(1 << row_idx).
- Blanking: dot_col = 0 while dwell_cnt==0, giving one blank cycle per row to suppress ghosting.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter.
  - Columns are driven only while pwm_cnt <= bright_q, otherwise dot_col = 0.
  - bright_q samples brightness at dwell_cnt==0 and is held for the rest of the row.
- Column data: dot_col = active row bits & PWM gate & ~blank.
- Mid-frame updates: the active buffer changes only at swap, never mid-frame.

## Timing
- Reset values (sampled while reset==0):
  - dot_row all ones, dot_col 0, frame_ready 1, frame_sync 0.
  - dwell_cnt, row_idx, pwm_cnt and bright_q 0; active and shadow buffers 0; pending 0.
- All outputs are registered and reflect counter state with 1-cycle latency.
- Row period is DWELL cycles; frame period is ROWS*DWELL cycles.
- Handshake-to-display latency: between 1 and ROWS*DWELL+1 cycles.
- Simultaneous valid and swap: frame_ready is 0 on the swap cycle, so no transfer occurs. A new frame is accepted from the cycle after.
- frame_valid held high: at most one frame is accepted per display frame.
- Reset mid-operation: all state returns to reset values at that edge and scanning restarts at row 0, dwell 0.

## Configuration
- DOT_SCALE_EN, when defined:
  - Adds the scale port.
  - With scale=1, only the low (ROWS/2)*(COLS/2) bits of the active buffer are used, laid out as a ROWS/2 x COLS/2 image (row-major, MSB first).
  - Output row r, column c shows image bit (r/2, c/2), giving the 2x2 replication of the legacy keypad display.
  - scale is sampled with bright_q.
- DOT_SCALE_EN undefined: no scale port and the bitmap is always shown 1:1.

## Structure
- Package dot_matrix_pkg holds:
  - the row-slice index function,
  - the scaled-pixel index function,
  - localparams for counter widths ($clog2(DWELL), $clog2(ROWS)).
- Sub-module dot_scan_timer holds dwell_cnt, row_idx and pwm_cnt, and outputs row_last, frame_last and blank. The top level holds the buffers, handshake, PWM gate and output registers.

## Test plan
- Reset hold then release with defaults -> dot_row 8'hFE for cycles 1..16, 8'hFD next; dot_col 0; frame_ready 1.
- Send frame with row 0 = 8'hA5, brightness 7, wait for frame_sync -> during row 0, dot_col 0 on the blank cycle, then 8'hA5 for 15 cycles.
- brightness 1 -> dot_col equals the data on 2 of every 8 pwm cycles, otherwise 0.
- Second frame offered while pending -> frame_ready 0 until the swap; the first frame is displayed intact for a full frame; the second is accepted the cycle after frame_sync.
- DOT_SCALE_EN with scale=1 and frame_data low 16 bits = 16'h8001 -> rows 0-1 show 8'hC0, rows 6-7 show 8'h03, other rows 0.
- Assert reset mid-row 5 -> next cycle all outputs at reset values, and scanning restarts at row 0 after release.

Source files
------------

// File: rtl/dot_matrix_pkg.sv
// Shared geometry defaults, counter widths and bitmap index helpers for the dot-matrix scanner.
// Optional 2x2 replication is enabled in the top level by defining DOT_SCALE_EN.
package dot_matrix_pkg;

    localparam int DOT_ROWS     = 8;
    localparam int DOT_COLS     = 8;
    localparam int DOT_DWELL    = 16;
    localparam int DOT_PWM_BITS = 3;

    localparam int DWELL_W = $clog2(DOT_DWELL);
    localparam int ROW_W   = $clog2(DOT_ROWS);

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Row 0 sits in the top COLS bits of the frame, MSB = leftmost column.
    function automatic int row_slice_lsb(input int row, input int rows, input int cols);
        return (rows - 1 - row) * cols;
    endfunction

    // Bit of the low (rows/2)*(cols/2) image shown at panel pixel (row, col) in 2x2 mode.
    function automatic int scaled_index(input int row, input int col, input int rows, input int cols);
        int half_w;
        half_w = cols / 2;
        return (rows / 2) * half_w - 1 - ((row / 2) * half_w + col / 2);
    endfunction

endpackage

// File: rtl/dot_scan_timer.sv
// Scan timebase: dwell counter within a row, row index within a frame, and a free-running PWM counter.
// Decodes the row-end, frame-end and blanking strobes used by the top level.
module dot_scan_timer
    import dot_matrix_pkg::*;
#(
    parameter int ROWS     = DOT_ROWS,
    parameter int DWELL    = DOT_DWELL,
    parameter int PWM_BITS = DOT_PWM_BITS,
    parameter int DW       = DWELL_W,
    parameter int RW       = ROW_W
) (
    input  logic                clock,
    input  logic                reset,
    output logic [RW-1:0]       row_idx,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                row_last,
    output logic                frame_last,
    output logic                blank
);

    logic [DW-1:0] dwell_cnt;

    assign row_last   = (dwell_cnt == DW'(DWELL - 1));
    assign frame_last = row_last && (row_idx == RW'(ROWS - 1));
    assign blank      = (dwell_cnt == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            dwell_cnt <= '0;
            row_idx   <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (row_last) begin
                dwell_cnt <= '0;
                row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scanning LED dot-matrix driver with tear-free shadow/active frame buffers and PWM dimming.
// Define DOT_SCALE_EN to add the scale port and 2x2 pixel replication of a quarter-size image.
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int ROWS     = DOT_ROWS,
    parameter int COLS     = DOT_COLS,
    parameter int DWELL    = DOT_DWELL,
    parameter int PWM_BITS = DOT_PWM_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ROWS*COLS-1:0]   frame_data,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [PWM_BITS-1:0]    brightness,
`ifdef DOT_SCALE_EN
    input  logic                   scale,
`endif
    output logic [ROWS-1:0]        dot_row,
    output logic [COLS-1:0]        dot_col,
    output logic                   frame_sync
);

    localparam int N  = ROWS * COLS;
    localparam int IW = cnt_width(N);
    localparam int DW = cnt_width(DWELL);
    localparam int RW = cnt_width(ROWS);

    logic [RW-1:0]       row_idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                row_last_unused;
    logic                frame_last;
    logic                blank;

    logic [N-1:0]        shadow;
    logic [N-1:0]        active;
    logic                pending;
    logic                swap_q;
    logic [PWM_BITS-1:0] bright_q;
`ifdef DOT_SCALE_EN
    logic                scale_q;
`endif

    logic                take;
    logic                swap;
    logic [IW-1:0]       slice_lsb;
    logic [COLS-1:0]     pix;
    logic [COLS-1:0]     col_next;
    logic [ROWS-1:0]     row_onehot;

    dot_scan_timer #(
        .ROWS     (ROWS),
        .DWELL    (DWELL),
        .PWM_BITS (PWM_BITS),
        .DW       (DW),
        .RW       (RW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .row_idx    (row_idx),
        .pwm_cnt    (pwm_cnt),
        .row_last   (row_last_unused),
        .frame_last (frame_last),
        .blank      (blank)
    );

    // Handshake: a frame transfers on any rising edge where frame_valid && frame_ready;
    // frame_ready is low exactly while a captured frame waits in the shadow buffer.
    assign frame_ready = ~pending;
    assign take        = frame_valid && frame_ready;
    assign swap        = frame_last && pending;

    always_comb begin
        slice_lsb  = IW'(row_slice_lsb(int'(row_idx), ROWS, COLS));
        pix        = active[slice_lsb +: COLS];
`ifdef DOT_SCALE_EN
        if (scale_q) begin
            for (int c = 0; c < COLS; c++) begin
                pix[COLS-1-c] = active[IW'(scaled_index(int'(row_idx), c, ROWS, COLS))];
            end
        end
`endif
        col_next   = (!blank && (pwm_cnt <= bright_q)) ? pix : '0;
        row_onehot = ROWS'(1) << row_idx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            swap_q     <= 1'b0;
            bright_q   <= '0;
`ifdef DOT_SCALE_EN
            scale_q    <= 1'b0;
`endif
            dot_row    <= '1;
            dot_col    <= '0;
            frame_sync <= 1'b0;
        end else begin
            if (take) begin
                shadow  <= frame_data;
                pending <= 1'b1;
            end else if (swap) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            // Delayed twice so the pulse lands on the first registered row-0 output.
            swap_q     <= swap;
            frame_sync <= swap_q;
            if (blank) begin
                bright_q <= brightness;
`ifdef DOT_SCALE_EN
                scale_q  <= scale;
`endif
            end
            dot_row <= ~row_onehot;
            dot_col <= col_next;
        end
    end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Directed bench for dot_matrix_scanner at the default 8x8 geometry, DWELL=16, PWM_BITS=3.
// Compile with DOT_SCALE_EN defined to also exercise the 2x2 replication path.
module tb_dot_matrix_scanner;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int DWELL    = 16;
    localparam int PWM_BITS = 3;

    localparam logic [63:0] F1 = 64'hA53C_817E_0FF0_55AA;
    localparam logic [63:0] F2 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] F3 = 64'hC35A_6996_1824_4281;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [63:0]          frame_data = '0;
    logic                 frame_valid = 1'b0;
    logic                 frame_ready;
    logic [PWM_BITS-1:0]  brightness = 3'd7;
`ifdef DOT_SCALE_EN
    logic                 scale = 1'b0;
`endif
    logic [ROWS-1:0]      dot_row;
    logic [COLS-1:0]      dot_col;
    logic                 frame_sync;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          samp     = 0;
    logic [7:0]  exp_row;
    logic [15:0] pwm1_on  = 16'h0302;
    logic [63:0] scale_exp = 64'hC0C0_0000_0000_0303;

    // clock / reset block
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    dot_matrix_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .DWELL    (DWELL),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
`ifdef DOT_SCALE_EN
        .scale       (scale),
`endif
        .dot_row     (dot_row),
        .dot_col     (dot_col),
        .frame_sync  (frame_sync)
    );

    function automatic logic [7:0] row_of(input logic [63:0] f, input int r);
        return f[63-8*r -: 8];
    endfunction

    // Output position (row, dwell) of the current sample; samp counts samples since reset release.
    function automatic int pos_r();
        return ((samp - 1) / DWELL) % ROWS;
    endfunction

    function automatic int pos_d();
        return (samp - 1) % DWELL;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (sample %0d)", tag, obs, exp, samp);
        end
    endtask

    // driver tasks: one rising edge, then settle at the falling edge
    task automatic step();
        logic rel;
        rel = reset;
        @(negedge clock);
        if (rel) samp++;
        else     samp = 0;
    endtask

    task automatic skip_to(input int r, input int d);
        int n;
        step();
        n = 1;
        while (!(samp > 0 && pos_r() == r && pos_d() == d) && n < 400) begin
            step();
            n++;
        end
        chk("skip_to_bound", (samp > 0 && pos_r() == r && pos_d() == d), 1);
    endtask

    task automatic wait_sync(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_sync !== 1'b1 && n < 400);
        chk(tag, frame_sync, 1);
    endtask

    initial begin
        // reset values
        reset = 1'b0;
        repeat (3) step();
        chk("rst_row", dot_row, 8'hFF);
        chk("rst_col", dot_col, 8'h00);
        chk("rst_ready", frame_ready, 1);
        chk("rst_sync", frame_sync, 0);

        // scanning from release: row 0 for 16 cycles, then row 1
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("row0_sel", dot_row, 8'hFE);
            chk("row0_col", dot_col, 8'h00);
        end
        step();
        chk("row1_sel", dot_row, 8'hFD);
        chk("idle_ready", frame_ready, 1);

        // first frame: handshake, swap at the frame boundary, full-brightness display
        frame_data  = F1;
        frame_valid = 1'b1;
        brightness  = 3'd7;
        chk("ready_before", frame_ready, 1);
        step();
        frame_valid = 1'b0;
        chk("ready_drop", frame_ready, 0);
        wait_sync("f1_sync");
        chk("f1_sync_pos", samp, 129);
        chk("f1_sync_ready", frame_ready, 1);
        chk("f1_sync_row", dot_row, 8'hFE);
        chk("f1_blank", dot_col, 8'h00);
        for (int d = 1; d < DWELL; d++) begin
            step();
            chk("f1_r0_col", dot_col, 8'hA5);
            chk("f1_r0_row", dot_row, 8'hFE);
            if (d == 1) chk("f1_sync_one_cycle", frame_sync, 0);
        end
        for (int r = 1; r < ROWS; r++) begin
            skip_to(r, 5);
            exp_row = ~(8'h01 << r);
            chk("f1_row_sel", dot_row, exp_row);
            chk("f1_row_col", dot_col, row_of(F1, r));
        end
        skip_to(0, 0);
        chk("no_pending_sync", frame_sync, 0);
        chk("no_pending_blank", dot_col, 8'h00);
        skip_to(0, 3);
        chk("active_kept", dot_col, 8'hA5);

        // brightness 1: on at pwm 0 and 1; a mid-row change waits for the next row
        brightness = 3'd1;
        skip_to(1, 0);
        chk("pwm_blank", dot_col, 8'h00);
        for (int d = 1; d < DWELL; d++) begin
            step();
            chk("pwm1_col", dot_col, pwm1_on[d] ? 8'h3C : 8'h00);
            if (d == 4) brightness = 3'd7;
        end
        skip_to(2, 2);
        chk("bright_restored", dot_col, 8'h81);

        // second frame while a third is offered: held off until the swap
        frame_data  = F2;
        frame_valid = 1'b1;
        step();
        frame_data = F3;
        chk("f2_taken_ready", frame_ready, 0);
        for (int n = 0; n < 200 && !(pos_r() == 7 && pos_d() == 14); n++) begin
            step();
            chk("pend_ready", frame_ready, 0);
            if (pos_d() == 5) chk("f1_intact", dot_col, row_of(F1, pos_r()));
        end
        chk("pend_reach", (pos_r() == 7 && pos_d() == 14), 1);
        step();
        chk("swap_ready_rise", frame_ready, 1);
        chk("last_row_sel", dot_row, 8'h7F);
        chk("last_row_old", dot_col, 8'hAA);
        step();
        chk("f2_sync", frame_sync, 1);
        chk("f3_accepted", frame_ready, 0);
        frame_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            skip_to(r, 5);
            chk("f2_row_col", dot_col, row_of(F2, r));
            if (r == 0) chk("f2_sync_low", frame_sync, 0);
        end
        skip_to(0, 0);
        chk("f3_sync", frame_sync, 1);
        skip_to(0, 5);
        chk("f3_r0_col", dot_col, 8'hC3);
        chk("f3_ready", frame_ready, 1);

        // reset in the middle of row 5 with a frame pending
        skip_to(5, 7);
        frame_data  = F1;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        chk("pre_reset_pending", frame_ready, 0);
        reset = 1'b0;
        step();
        chk("mid_rst_row", dot_row, 8'hFF);
        chk("mid_rst_col", dot_col, 8'h00);
        chk("mid_rst_ready", frame_ready, 1);
        chk("mid_rst_sync", frame_sync, 0);
        step();
        reset = 1'b1;
        step();
        chk("restart_row", dot_row, 8'hFE);
        chk("restart_blank", dot_col, 8'h00);
        repeat (4) begin
            step();
            chk("active_cleared", dot_col, 8'h00);
        end
        skip_to(0, 0);
        chk("pending_cleared", frame_sync, 0);
        chk("restart_frame_row", dot_row, 8'hFE);
        skip_to(0, 5);
        chk("still_dark", dot_col, 8'h00);

`ifdef DOT_SCALE_EN
        // 2x2 replication of the low 16 bits
        scale       = 1'b1;
        frame_data  = 64'hDEAD_BEEF_0000_8001;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        wait_sync("scale_sync");
        for (int r = 0; r < ROWS; r++) begin
            skip_to(r, 5);
            chk("scale_row_col", dot_col, row_of(scale_exp, r));
        end
`endif

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
